buzz_scheduler: RTL and testbench
=================================

# buzz_scheduler

Shares the single piezo buzzer between three requesters: alarm, hourly chime and key-click. The block arbitrates by fixed priority and sequences on/off beep cadences. It also generates the audible square-wave tone. It sits between the clock/alarm control logic and the buzzer pin, replacing direct enable-driven beeping with one scheduled owner.

## Interface
Parameters:
- TICK_DIV, 5000000: clocks per cadence tick (100 ms at 50 MHz).
- TONE_DIV, 12500: clocks per tone half-period (2 kHz at 50 MHz).
- ON_TICKS, 3: ticks per beep ON phase (alarm, chime).
- OFF_TICKS, 2: ticks per OFF gap after every beep.
- KEY_TICKS, 1: ticks per key-click ON phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- alarm_req  in  1  level; beep repeatedly while high.
- chime_req  in  1  one-cycle pulse; beep chime_n times.
- chime_n  in  4  beep count, sampled with chime_req; 0 = ignore request.
- key_req  in  1  one-cycle pulse; single short click.
- buzz_out  out  1  tone output to buzzer pin.
- busy  out  1  high while any sequence (including trailing gap) runs.
- grant  out  3  one-hot owner: [2] alarm, [1] chime, [0] key; 0 when idle.

## Operation
- FSM states: IDLE, ON, OFF.
- Priority: alarm > chime > key.
- IDLE to ON: on the highest pending/asserted request.
  - Tick prescaler, tone divider and tone register all clear.
  - Phase counter loads ON_TICKS, or KEY_TICKS for key.
- ON to OFF: phase counter expires; counter loads OFF_TICKS.
- OFF to ON: when another beep remains.
  - Alarm: alarm_req still high.
  - Chime: beep counter nonzero after decrement.
- OFF to IDLE: otherwise, at the end of the gap.
- A pending chime is served at that point if one exists.
- Tone generation:
  - In ON, the tone register toggles every TONE_DIV clocks.
  - buzz_out = tone register AND (state == ON).
  - In OFF/IDLE, buzz_out is 0.
- Chime pending latch:
  - chime_req with chime_n != 0 latches chime_n if the block is busy with alarm or another chime.
  - Holds one entry; a newer request overwrites it.
- key_req while busy: dropped.
- Alarm preemption: alarm_req rising while chime/key active.
  - Abort at the next edge and restart in ON for alarm.
  - The preempted chime is discarded, not resumed.
- alarm_req falling mid-ON: the current beep and its OFF gap complete, then the FSM leaves the sequence.
- Simultaneous requests in one cycle: highest priority wins.
  - A simultaneous chime is latched pending.
  - A simultaneous key is dropped.
- Beep counter: 4-bit, loaded from chime_n, decremented on each ON to OFF; no wrap (0 is terminal).

## Timing
- Reset values:
  - buzz_out = 0, busy = 0, grant = 3'b000, state IDLE.
  - Pending latch cleared; all counters 0.
- Request latency: request sampled at edge N; state ON, busy and grant valid from edge N+1.
- First tone rising edge at N+1+TONE_DIV.
- ON phase length: exactly ON_TICKS×TICK_DIV clocks (key: KEY_TICKS×TICK_DIV).
- OFF phase length: exactly OFF_TICKS×TICK_DIV clocks.
- busy falls on the edge where OFF expires; grant clears on the same edge.
- Back-to-back: a pending chime starts on that same edge with no idle cycle; busy stays high.
- rst mid-sequence: all outputs go low immediately (asynchronously); the pending request is lost.

## Configuration
- BUZZ_SCHED_KEYBEEP_EN defined: key-click requester present as described.
- Undefined:
  - key_req is ignored; grant[0] is tied 0.
  - KEY_TICKS is unused; the key path logic is not synthesized.

## Test plan
Bench parameters: TICK_DIV=4, TONE_DIV=2, ON_TICKS=3, OFF_TICKS=2, KEY_TICKS=1.
- Chime: chime_req with chime_n=3 from idle -> three 12-clock ON bursts, each followed by an 8-clock gap; busy high exactly 60 clocks; grant=3'b010; buzz_out toggles every 2 clocks in ON.
- Alarm: alarm_req high for 30 clocks -> ON 12 clocks, OFF 8, ON 12, OFF 8; busy drops after 40 clocks; grant=3'b100.
- Preemption: chime_n=5 running, alarm_req rises during beep 2 -> next edge grant=3'b100 with a fresh 12-clock ON; the chime never resumes after the alarm ends.
- Pending/simultaneous: alarm_req and chime_req (chime_n=2) in the same cycle, alarm held 10 clocks -> alarm completes 20 clocks, then the chime starts on the same edge busy would fall; 40 more clocks; key_req mid-sequence has no effect.
- Key click (macro on): key_req from idle -> 4-clock ON, 8-clock OFF, grant=3'b001. Macro off: no response.
- Reset: rst asserted mid-ON -> buzz_out, busy and grant go to 0 immediately; after release with no request, they stay 0.

Source files
------------

// File: rtl/buzz_scheduler.sv
// Buzzer owner arbiter: fixed-priority alarm > chime > key, ON/OFF beep cadence and tone generation.
// Define BUZZ_SCHED_KEYBEEP_EN to build the key-click requester; without it key_req is ignored.
module buzz_scheduler #(
    parameter int TICK_DIV  = 5000000,
    parameter int TONE_DIV  = 12500,
    parameter int ON_TICKS  = 3,
    parameter int OFF_TICKS = 2,
    parameter int KEY_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_req,
    input  logic       chime_req,
    input  logic [3:0] chime_n,
    input  logic       key_req,
    output logic       buzz_out,
    output logic       busy,
    output logic [2:0] grant
);

    localparam int PH_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_MAX   = (PH_MAX_A > KEY_TICKS) ? PH_MAX_A : KEY_TICKS;
    localparam int TICK_W   = $clog2(TICK_DIV + 1);
    localparam int TONE_W   = $clog2(TONE_DIV + 1);
    localparam int PH_W     = $clog2(PH_MAX + 1);

    localparam logic [2:0] G_NONE  = 3'b000;
    localparam logic [2:0] G_ALARM = 3'b100;
    localparam logic [2:0] G_CHIME = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_grant;
    logic [2:0]          w_grant_nxt;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [TONE_W-1:0]   r_tone_cnt;
    logic                r_tone;
    logic [PH_W-1:0]     r_phase_cnt;
    logic [3:0]          r_beep_cnt;
    logic                r_pend_vld;
    logic [3:0]          r_pend_n;

    logic                w_tick;
    logic                w_phase_done;
    logic                w_new_chime;
    logic                w_chime_avail;
    logic [3:0]          w_chime_sel_n;
    logic                w_preempt;
    logic                w_enter_on;
    logic                w_enter_off;
    logic                w_take_chime;
    logic                w_clear_beep;
    logic [PH_W-1:0]     w_ph_load;

`ifndef BUZZ_SCHED_KEYBEEP_EN
    logic w_unused_key;
    assign w_unused_key = key_req;
`endif

    assign w_tick        = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_phase_done  = w_tick && (r_phase_cnt == PH_W'(1));
    assign w_new_chime   = chime_req && (chime_n != 4'd0);
    assign w_chime_avail = w_new_chime || r_pend_vld;
    // A chime arriving on the same edge as a serve point supersedes the held one.
    assign w_chime_sel_n = w_new_chime ? chime_n : r_pend_n;
    assign w_preempt     = (r_state != S_IDLE) && (r_grant != G_ALARM) && alarm_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= G_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_enter_on   = 1'b0;
        w_enter_off  = 1'b0;
        w_take_chime = 1'b0;
        w_clear_beep = 1'b0;
        w_ph_load    = PH_W'(ON_TICKS);
        case (r_state)
            S_IDLE: begin
                if (alarm_req) begin
                    w_state_nxt  = S_ON;
                    w_grant_nxt  = G_ALARM;
                    w_enter_on   = 1'b1;
                    w_clear_beep = 1'b1;
                end else if (w_chime_avail) begin
                    w_state_nxt  = S_ON;
                    w_grant_nxt  = G_CHIME;
                    w_enter_on   = 1'b1;
                    w_take_chime = 1'b1;
`ifdef BUZZ_SCHED_KEYBEEP_EN
                end else if (key_req) begin
                    w_state_nxt  = S_ON;
                    w_grant_nxt  = 3'b001;
                    w_enter_on   = 1'b1;
                    w_clear_beep = 1'b1;
                    w_ph_load    = PH_W'(KEY_TICKS);
`endif
                end
            end
            S_ON: begin
                if (w_preempt) begin
                    w_grant_nxt  = G_ALARM;
                    w_enter_on   = 1'b1;
                    w_clear_beep = 1'b1;
                end else if (w_phase_done) begin
                    w_state_nxt = S_OFF;
                    w_enter_off = 1'b1;
                end
            end
            S_OFF: begin
                if (w_preempt || (w_phase_done && alarm_req)) begin
                    w_state_nxt  = S_ON;
                    w_grant_nxt  = G_ALARM;
                    w_enter_on   = 1'b1;
                    w_clear_beep = 1'b1;
                end else if (w_phase_done) begin
                    if ((r_grant == G_CHIME) && (r_beep_cnt != 4'd0)) begin
                        w_state_nxt = S_ON;
                        w_enter_on  = 1'b1;
                    end else if (w_chime_avail) begin
                        w_state_nxt  = S_ON;
                        w_grant_nxt  = G_CHIME;
                        w_enter_on   = 1'b1;
                        w_take_chime = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = G_NONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = G_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_tone_cnt  <= '0;
            r_tone      <= 1'b0;
            r_phase_cnt <= '0;
            r_beep_cnt  <= 4'd0;
            r_pend_vld  <= 1'b0;
            r_pend_n    <= 4'd0;
        end else begin
            if (w_enter_on) begin
                r_tick_cnt  <= '0;
                r_phase_cnt <= w_ph_load;
            end else if (w_enter_off) begin
                r_tick_cnt  <= '0;
                r_phase_cnt <= PH_W'(OFF_TICKS);
            end else if (r_state != S_IDLE) begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
                if (w_tick) r_phase_cnt <= r_phase_cnt - PH_W'(1);
            end

            // Each beep restarts the tone so its first rising edge is TONE_DIV clocks in.
            if (w_enter_on) begin
                r_tone_cnt <= '0;
                r_tone     <= 1'b0;
            end else if (r_state == S_ON) begin
                if (r_tone_cnt == TONE_W'(TONE_DIV - 1)) begin
                    r_tone_cnt <= '0;
                    r_tone     <= ~r_tone;
                end else begin
                    r_tone_cnt <= r_tone_cnt + TONE_W'(1);
                end
            end

            if (w_take_chime)
                r_beep_cnt <= w_chime_sel_n;
            else if (w_clear_beep)
                r_beep_cnt <= 4'd0;
            else if (w_enter_off && (r_beep_cnt != 4'd0))
                r_beep_cnt <= r_beep_cnt - 4'd1;

            if (w_take_chime) begin
                r_pend_vld <= 1'b0;
            end else if (w_new_chime) begin
                r_pend_vld <= 1'b1;
                r_pend_n   <= chime_n;
            end
        end
    end

    assign buzz_out = r_tone && (r_state == S_ON);
    assign busy     = (r_state != S_IDLE);
    assign grant    = r_grant;

endmodule

// File: tb/tb_buzz_scheduler.sv
// Self-checking bench for buzz_scheduler: randomized directed scenarios against an arithmetic cadence model.
module tb_buzz_scheduler;

    localparam int TICK    = 4;
    localparam int TONE    = 2;
    localparam int ONT     = 3;
    localparam int OFFT    = 2;
    localparam int KEYT    = 1;
    localparam int ON_LEN  = ONT * TICK;
    localparam int OFF_LEN = OFFT * TICK;
    localparam int KEY_LEN = KEYT * TICK;

    logic       clk = 1'b0;
    logic       rst;
    logic       alarm_req;
    logic       chime_req;
    logic [3:0] chime_n;
    logic       key_req;
    logic       buzz_out;
    logic       busy;
    logic [2:0] grant;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    buzz_scheduler #(
        .TICK_DIV (TICK),
        .TONE_DIV (TONE),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFFT),
        .KEY_TICKS(KEYT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alarm_req(alarm_req),
        .chime_req(chime_req),
        .chime_n  (chime_n),
        .key_req  (key_req),
        .buzz_out (buzz_out),
        .busy     (busy),
        .grant    (grant)
    );

    // Expected {busy, grant, buzz_out} at clock t of a beep sequence owned by g.
    function automatic logic [4:0] beep_vec(input logic [2:0] g, input int on_len, input int t);
        int   b;
        logic tone_hi;
        b       = t % (on_len + OFF_LEN);
        tone_hi = (b < on_len) && (((b / TONE) % 2) == 1);
        return {1'b1, g, tone_hi};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {busy, grant, buzz_out};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (busy,grant,buzz) at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_beeps(input string tag, input logic [2:0] g, input int on_len, input int beeps);
        for (int t = 0; t < beeps * (on_len + OFF_LEN); t++) begin
            check(tag, beep_vec(g, on_len, t));
            step();
        end
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        for (int t = 0; t < cycles; t++) begin
            check(tag, 5'b0);
            step();
        end
    endtask

    // Alarm already raised before the current edge; it stays high for h sampled edges.
    task automatic alarm_body(input string tag, input int h);
        int beeps;
        beeps = (h + ON_LEN + OFF_LEN - 1) / (ON_LEN + OFF_LEN);
        for (int t = 0; t < beeps * (ON_LEN + OFF_LEN); t++) begin
            check(tag, beep_vec(3'b100, ON_LEN, t));
            if (t == h - 1) alarm_req = 1'b0;
            step();
        end
    endtask

    initial begin
        int n;
        int h;
        int r;
        int kt;
        int n2;
        int n_exp;

        rst       = 1'b1;
        alarm_req = 1'b0;
        chime_req = 1'b0;
        chime_n   = 4'd0;
        key_req   = 1'b0;
        step();
        step();
        check("reset", 5'b0);
        rst = 1'b0;
        expect_idle("post_reset", 3);

        // Chime from idle: n beeps, directed n=3 first.
        for (int it = 0; it < 3; it++) begin
            n = (it == 0) ? 3 : $urandom_range(1, 6);
            chime_req = 1'b1;
            chime_n   = 4'(n);
            step();
            chime_req = 1'b0;
            chime_n   = 4'd0;
            expect_beeps("chime", 3'b010, ON_LEN, n);
            expect_idle("chime_end", 3);
        end

        chime_req = 1'b1;
        chime_n   = 4'd0;
        step();
        chime_req = 1'b0;
        expect_idle("chime_n0", 5);

        // Alarm level held h clocks, directed h=30 first.
        for (int it = 0; it < 3; it++) begin
            h = (it == 0) ? 30 : $urandom_range(1, 60);
            alarm_req = 1'b1;
            step();
            alarm_body("alarm", h);
            expect_idle("alarm_end", 3);
        end

        // Alarm preempts a 5-beep chime during its second beep.
        chime_req = 1'b1;
        chime_n   = 4'd5;
        step();
        chime_req = 1'b0;
        chime_n   = 4'd0;
        r = $urandom_range(ON_LEN + OFF_LEN, 2 * ON_LEN + OFF_LEN - 1);
        for (int t = 0; t <= r; t++) begin
            check("pre_chime", beep_vec(3'b010, ON_LEN, t));
            if (t == r) alarm_req = 1'b1;
            step();
        end
        alarm_body("pre_alarm", $urandom_range(1, 25));
        expect_idle("pre_noresume", 40);

        // Simultaneous alarm + chime, key click and an overwriting chime while busy.
        for (int it = 0; it < 2; it++) begin
            h     = (it == 0) ? 10 : $urandom_range(1, 20);
            n     = (it == 0) ? 2 : $urandom_range(1, 4);
            n2    = $urandom_range(1, 4);
            kt    = $urandom_range(2, 15);
            n_exp = (it == 0) ? n : n2;
            alarm_req = 1'b1;
            chime_req = 1'b1;
            chime_n   = 4'(n);
            key_req   = 1'b1;
            step();
            chime_req = 1'b0;
            chime_n   = 4'd0;
            key_req   = 1'b0;
            for (int t = 0; t < ON_LEN + OFF_LEN; t++) begin
                check("sim_alarm", beep_vec(3'b100, ON_LEN, t));
                if (t == h - 1) alarm_req = 1'b0;
                key_req = (t == kt);
                if ((it == 1) && (t == kt + 2)) begin
                    chime_req = 1'b1;
                    chime_n   = 4'(n2);
                end else begin
                    chime_req = 1'b0;
                    chime_n   = 4'd0;
                end
                step();
            end
            key_req = 1'b0;
            expect_beeps("sim_chime", 3'b010, ON_LEN, n_exp);
            expect_idle("sim_end", 3);
        end

        // Key click from idle.
        key_req = 1'b1;
        step();
        key_req = 1'b0;
`ifdef BUZZ_SCHED_KEYBEEP_EN
        expect_beeps("key", 3'b001, KEY_LEN, 1);
`else
        expect_idle("key_off", KEY_LEN + OFF_LEN);
`endif
        expect_idle("key_end", 3);

        // Asynchronous reset mid-ON with a chime held pending.
        alarm_req = 1'b1;
        chime_req = 1'b1;
        chime_n   = 4'd3;
        step();
        chime_req = 1'b0;
        chime_n   = 4'd0;
        r = $urandom_range(0, ON_LEN - 2);
        for (int t = 0; t < r; t++) begin
            check("rst_pre", beep_vec(3'b100, ON_LEN, t));
            step();
        end
        check("rst_pre", beep_vec(3'b100, ON_LEN, r));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 5'b0);
        alarm_req = 1'b0;
        step();
        check("rst_held", 5'b0);
        rst = 1'b0;
        expect_idle("rst_after", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
